// File: rtl/wishbone_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The arbiter uses the slave modport toward each master and the master modport toward memory.
interface wishbone_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, adr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter with a bus watchdog that errors out
// slave cycles which never acknowledge.
module wishbone_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  wishbone_arbiter_if.slave     m0,
  wishbone_arbiter_if.slave     m1,
  wishbone_arbiter_if.master    s,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic       last_gnt;
  logic [7:0] count;
  logic       own_cyc;
  logic       own_stb;
  logic       at_limit;
  logic       timeout;

  assign gnt_o    = {state == GNT1, state == GNT0};
  assign at_limit = (count == TIMEOUT_CNT);
  assign timeout  = own_stb & ~s.ack & at_limit;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      GNT0: begin
        own_cyc = m0.cyc;
        own_stb = m0.stb;
      end
      GNT1: begin
        own_cyc = m1.cyc;
        own_stb = m1.stb;
      end
      default: ;
    endcase
  end

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = {ADDR_W{1'b0}};
    s.wdata = {DATA_W{1'b0}};
    case (state)
      GNT0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.adr   = m0.adr;
        s.wdata = m0.wdata;
      end
      GNT1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.adr   = m1.adr;
        s.wdata = m1.wdata;
      end
      default: ;
    endcase
  end

  // A same-cycle ack always beats the watchdog, so err is masked by s.ack.
  always_comb begin
    m0.ack   = s.ack & gnt_o[0] & m0.stb;
    m1.ack   = s.ack & gnt_o[1] & m1.stb;
    m0.err   = gnt_o[0] & m0.stb & ~s.ack & at_limit;
    m1.err   = gnt_o[1] & m1.stb & ~s.ack & at_limit;
    m0.rdata = gnt_o[0] ? s.rdata : {DATA_W{1'b0}};
    m1.rdata = gnt_o[1] ? s.rdata : {DATA_W{1'b0}};
  end

  // Every ownership returns through IDLE, which guarantees the idle gap between owners.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      count    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          count <= 8'd0;
          if (m0.cyc && (!m1.cyc || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (m1.cyc) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        default: begin
          if (!own_cyc || timeout) begin
            state <= IDLE;
            count <= 8'd0;
          end else if (own_stb && !s.ack) begin
            count <= count + 8'd1;
          end else begin
            count <= 8'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: single read, tie break, round robin,
// grant hold, watchdog timeout and reset mid-cycle.
module tb_wishbone_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] gnt;
  int vectors = 0;
  int miscompares = 0;

  wishbone_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m0_bus ();
  wishbone_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m1_bus ();
  wishbone_arbiter_if #(.ADDR_W(16), .DATA_W(8)) s_bus ();

  wishbone_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt_o (gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [15:0] adr, input logic [7:0] dat);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr; m0_bus.wdata = dat;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr; m1_bus.wdata = dat;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    applyStimulus(1, 0, 0, 0, 16'h0, 8'h0);
    s_bus.ack = 1'b0;
    s_bus.err = 1'b0;
    s_bus.rdata = 8'hFF;
    tick();
    tick();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_s_cyc", 32'(s_bus.cyc), 32'h0);
    checkOutput("reset_m0_ack", 32'(m0_bus.ack), 32'h0);
    checkOutput("reset_m0_err", 32'(m0_bus.err), 32'h0);
    checkOutput("reset_m0_dat", 32'(m0_bus.rdata), 32'h0);
    reset = 1'b0;
    tick();

    // Master 0 single read, ack two cycles after strobe.
    applyStimulus(0, 1, 1, 0, 16'h0010, 8'h0);
    #1;
    checkOutput("t1_gnt_before", 32'(gnt), 32'h0);
    tick();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_s_cyc", 32'(s_bus.cyc), 32'h1);
    checkOutput("t1_s_adr", 32'(s_bus.adr), 32'h0010);
    checkOutput("t1_m0_ack_wait", 32'(m0_bus.ack), 32'h0);
    tick();
    tick();
    s_bus.ack = 1'b1;
    s_bus.rdata = 8'hA5;
    #1;
    checkOutput("t1_m0_ack", 32'(m0_bus.ack), 32'h1);
    checkOutput("t1_m0_dat", 32'(m0_bus.rdata), 32'hA5);
    checkOutput("t1_m1_ack", 32'(m1_bus.ack), 32'h0);
    checkOutput("t1_m1_dat", 32'(m1_bus.rdata), 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    s_bus.ack = 1'b0;
    tick();
    checkOutput("t1_gnt_idle", 32'(gnt), 32'h0);

    // Simultaneous requests straight after reset: master 0 wins the tie.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0, 16'h0, 8'h0);
    applyStimulus(1, 1, 0, 0, 16'h0, 8'h0);
    tick();
    checkOutput("t2_gnt_first", 32'(gnt), 32'h1);
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    tick();
    checkOutput("t2_gnt_gap", 32'(gnt), 32'h0);
    tick();
    checkOutput("t2_gnt_second", 32'(gnt), 32'h2);

    // Round robin with both masters continuously re-requesting.
    applyStimulus(1, 0, 0, 0, 16'h0, 8'h0);
    tick();
    checkOutput("t3_gnt_start", 32'(gnt), 32'h0);
    applyStimulus(0, 1, 1, 0, 16'h0020, 8'h0);
    applyStimulus(1, 1, 1, 0, 16'h0030, 8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t3_gnt_%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      s_bus.ack = 1'b1;
      s_bus.rdata = 8'h30 + 8'(i);
      #1;
      if (i % 2 == 0) begin
        checkOutput($sformatf("t3_m0_ack_%0d", i), 32'(m0_bus.ack), 32'h1);
        checkOutput($sformatf("t3_m1_ack_%0d", i), 32'(m1_bus.ack), 32'h0);
        checkOutput($sformatf("t3_m0_dat_%0d", i), 32'(m0_bus.rdata), 32'h30 + 32'(i));
        applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
      end else begin
        checkOutput($sformatf("t3_m1_ack_%0d", i), 32'(m1_bus.ack), 32'h1);
        checkOutput($sformatf("t3_m0_ack_%0d", i), 32'(m0_bus.ack), 32'h0);
        checkOutput($sformatf("t3_m1_dat_%0d", i), 32'(m1_bus.rdata), 32'h30 + 32'(i));
        applyStimulus(1, 0, 0, 0, 16'h0, 8'h0);
      end
      s_bus.ack = 1'b0;
      tick();
      checkOutput($sformatf("t3_gap_%0d", i), 32'(gnt), 32'h0);
      if (i % 2 == 0) applyStimulus(0, 1, 1, 0, 16'h0020, 8'h0);
      else            applyStimulus(1, 1, 1, 0, 16'h0030, 8'h0);
    end

    // Grant hold: master 1 keeps cyc for four writes while master 0 waits.
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    applyStimulus(1, 1, 0, 0, 16'h0, 8'h0);
    tick();
    checkOutput("t4_gnt", 32'(gnt), 32'h2);
    applyStimulus(0, 1, 1, 0, 16'h0050, 8'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 1, 1, 16'h0100 + 16'(k), 8'h11 + 8'(k));
      s_bus.ack = 1'b1;
      #1;
      checkOutput($sformatf("t4_gnt_%0d", k), 32'(gnt), 32'h2);
      checkOutput($sformatf("t4_adr_%0d", k), 32'(s_bus.adr), 32'h0100 + 32'(k));
      checkOutput($sformatf("t4_dat_%0d", k), 32'(s_bus.wdata), 32'h11 + 32'(k));
      checkOutput($sformatf("t4_we_%0d", k), 32'(s_bus.we), 32'h1);
      checkOutput($sformatf("t4_m0_ack_%0d", k), 32'(m0_bus.ack), 32'h0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 16'h0, 8'h0);
    s_bus.ack = 1'b0;
    tick();
    checkOutput("t4_gnt_release", 32'(gnt), 32'h0);
    tick();
    checkOutput("t4_gnt_m0", 32'(gnt), 32'h1);

    // Watchdog: slave never acks, err pulses on the 16th strobe cycle.
    for (int t = 1; t <= 16; t++) begin
      #1;
      checkOutput($sformatf("t5_err_%0d", t), 32'(m0_bus.err), (t == 16) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t5_cyc_%0d", t), 32'(s_bus.cyc), 32'h1);
      tick();
    end
    checkOutput("t5_s_cyc_after", 32'(s_bus.cyc), 32'h0);
    checkOutput("t5_gnt_after", 32'(gnt), 32'h0);
    checkOutput("t5_err_after", 32'(m0_bus.err), 32'h0);
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    tick();

    // Same watchdog limit, but the ack arrives on that cycle: ack wins.
    applyStimulus(0, 1, 1, 0, 16'h0060, 8'h0);
    tick();
    for (int t = 1; t <= 15; t++) tick();
    s_bus.ack = 1'b1;
    s_bus.rdata = 8'h5A;
    #1;
    checkOutput("t5v_err", 32'(m0_bus.err), 32'h0);
    checkOutput("t5v_ack", 32'(m0_bus.ack), 32'h1);
    tick();
    checkOutput("t5v_gnt_held", 32'(gnt), 32'h1);
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0);
    s_bus.ack = 1'b0;
    tick();

    // Reset while master 1 owns the bus with a strobe pending.
    applyStimulus(1, 1, 1, 0, 16'h0070, 8'h0);
    tick();
    checkOutput("t6_gnt_m1", 32'(gnt), 32'h2);
    tick();
    reset = 1'b1;
    applyStimulus(0, 1, 1, 0, 16'h0080, 8'h0);
    tick();
    checkOutput("t6_gnt_reset", 32'(gnt), 32'h0);
    checkOutput("t6_s_cyc_reset", 32'(s_bus.cyc), 32'h0);
    checkOutput("t6_m1_ack_reset", 32'(m1_bus.ack), 32'h0);
    checkOutput("t6_m1_err_reset", 32'(m1_bus.err), 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("t6_tie_m0", 32'(gnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
